// File: rtl/match_scoreboard.sv
// First-to-N match scoreboard: counts rounds, wins, losses, draws and win streak,
// and declares a winner at the target score or at the round limit.
module match_scoreboard #(
   parameter int CNT_W      = 4,
   parameter int WIN_TARGET = 3,
   parameter int MAX_ROUNDS = 9
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             new_game,
   input  logic             result_valid,
   input  logic [1:0]       matchresult,
   output logic             result_ready,
   output logic [CNT_W-1:0] round,
   output logic [CNT_W-1:0] win,
   output logic [CNT_W-1:0] lose,
   output logic [CNT_W-1:0] draw,
   output logic [CNT_W-1:0] streak,
   output logic             game_over,
   output logic [1:0]       winner
);

   typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

   localparam logic [CNT_W-1:0] TARGET = CNT_W'(WIN_TARGET);
   localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(MAX_ROUNDS);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t           state_reg,  state_next;
   logic [CNT_W-1:0] round_reg,  round_next;
   logic [CNT_W-1:0] win_reg,    win_next;
   logic [CNT_W-1:0] lose_reg,   lose_next;
   logic [CNT_W-1:0] draw_reg,   draw_next;
   logic [CNT_W-1:0] streak_reg, streak_next;
   logic [1:0]       winner_reg, winner_next;
   logic [1:0]       sync_reg;
   logic             accept;

   // Reset release is pipelined through two flops before results may be accepted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync_reg <= 2'b00;
      else         sync_reg <= {sync_reg[0], 1'b1};
   end

   assign accept = sync_reg[1] && (state_reg == PLAY) && result_valid &&
                   !new_game && (matchresult != 2'b00);

   always_comb begin
      state_next  = state_reg;
      round_next  = round_reg;
      win_next    = win_reg;
      lose_next   = lose_reg;
      draw_next   = draw_reg;
      streak_next = streak_reg;
      winner_next = winner_reg;
      if (new_game) begin
         state_next  = PLAY;
         round_next  = '0;
         win_next    = '0;
         lose_next   = '0;
         draw_next   = '0;
         streak_next = '0;
         winner_next = 2'b00;
      end else if (accept) begin
         round_next = round_reg + ONE;
         case (matchresult)
            2'b01: begin
               draw_next   = draw_reg + ONE;
               streak_next = '0;
            end
            2'b10: begin
               win_next    = win_reg + ONE;
               streak_next = streak_reg + ONE;
            end
            2'b11: begin
               lose_next   = lose_reg + ONE;
               streak_next = '0;
            end
            default: ;
         endcase
         // Reaching the target outranks the round limit.
         if (win_next == TARGET) begin
            state_next  = OVER;
            winner_next = 2'b01;
         end else if (lose_next == TARGET) begin
            state_next  = OVER;
            winner_next = 2'b10;
         end else if (round_next == LIMIT) begin
            state_next = OVER;
            if (win_next > lose_next)      winner_next = 2'b01;
            else if (lose_next > win_next) winner_next = 2'b10;
            else                           winner_next = 2'b11;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg  <= PLAY;
         round_reg  <= '0;
         win_reg    <= '0;
         lose_reg   <= '0;
         draw_reg   <= '0;
         streak_reg <= '0;
         winner_reg <= 2'b00;
      end else begin
         state_reg  <= state_next;
         round_reg  <= round_next;
         win_reg    <= win_next;
         lose_reg   <= lose_next;
         draw_reg   <= draw_next;
         streak_reg <= streak_next;
         winner_reg <= winner_next;
      end
   end

   assign result_ready = (state_reg == PLAY);
   assign game_over    = (state_reg == OVER);
   assign round        = round_reg;
   assign win          = win_reg;
   assign lose         = lose_reg;
   assign draw         = draw_reg;
   assign streak       = streak_reg;
   assign winner       = winner_reg;

endmodule

// File: tb/tb_match_scoreboard.sv
// Bench for match_scoreboard: a behavioural model pushes expected outputs per
// driven cycle into a queue; they are popped and compared one cycle later.
module tb_match_scoreboard;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       new_game = 1'b0;
   logic       result_valid = 1'b0;
   logic [1:0] matchresult = 2'b00;
   logic       result_ready;
   logic [3:0] round, win, lose, draw, streak;
   logic       game_over;
   logic [1:0] winner;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] round, win, lose, draw, streak;
      logic       over;
      logic [1:0] winner;
      string      tag;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state
   int   m_round, m_win, m_lose, m_draw, m_streak;
   logic m_over;
   logic [1:0] m_winner;

   match_scoreboard #(.CNT_W(4), .WIN_TARGET(3), .MAX_ROUNDS(9)) dut (
      .clk(clk), .resetn(resetn), .new_game(new_game),
      .result_valid(result_valid), .matchresult(matchresult),
      .result_ready(result_ready), .round(round), .win(win), .lose(lose),
      .draw(draw), .streak(streak), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      m_round = 0; m_win = 0; m_lose = 0; m_draw = 0; m_streak = 0;
      m_over = 1'b0; m_winner = 2'b00;
   endtask

   task automatic model_step(input logic ng, input logic v, input logic [1:0] mr);
      if (ng) begin
         model_clear();
      end else if (!m_over && v && mr != 2'b00) begin
         m_round++;
         if (mr == 2'b01) begin m_draw++; m_streak = 0; end
         else if (mr == 2'b10) begin m_win++; m_streak++; end
         else begin m_lose++; m_streak = 0; end
         if (m_win == 3) begin m_over = 1'b1; m_winner = 2'b01; end
         else if (m_lose == 3) begin m_over = 1'b1; m_winner = 2'b10; end
         else if (m_round == 9) begin
            m_over = 1'b1;
            m_winner = (m_win > m_lose) ? 2'b01 : (m_lose > m_win) ? 2'b10 : 2'b11;
         end
      end
   endtask

   // Drive one cycle of stimulus, push the model's expectation, pop and score after the edge.
   task automatic step(input string tag, input logic ng, input logic v, input logic [1:0] mr);
      exp_t e;
      @(negedge clk);
      new_game = ng; result_valid = v; matchresult = mr;
      model_step(ng, v, mr);
      e.round = 4'(m_round); e.win = 4'(m_win); e.lose = 4'(m_lose);
      e.draw = 4'(m_draw); e.streak = 4'(m_streak); e.over = m_over;
      e.winner = m_winner; e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      $display("txn %s ng=%0b v=%0b mr=%b -> r=%0d w=%0d l=%0d d=%0d s=%0d over=%0b rdy=%0b win=%b",
               e.tag, ng, v, mr, round, win, lose, draw, streak, game_over, result_ready, winner);
      total++; if (round  !== e.round)  begin bad++; $display("FAIL %s round got=%0d want=%0d", e.tag, round, e.round); end
      total++; if (win    !== e.win)    begin bad++; $display("FAIL %s win got=%0d want=%0d", e.tag, win, e.win); end
      total++; if (lose   !== e.lose)   begin bad++; $display("FAIL %s lose got=%0d want=%0d", e.tag, lose, e.lose); end
      total++; if (draw   !== e.draw)   begin bad++; $display("FAIL %s draw got=%0d want=%0d", e.tag, draw, e.draw); end
      total++; if (streak !== e.streak) begin bad++; $display("FAIL %s streak got=%0d want=%0d", e.tag, streak, e.streak); end
      total++; if (game_over !== e.over) begin bad++; $display("FAIL %s game_over got=%0b want=%0b", e.tag, game_over, e.over); end
      total++; if (result_ready !== !e.over) begin bad++; $display("FAIL %s result_ready got=%0b want=%0b", e.tag, result_ready, !e.over); end
      total++; if (winner !== e.winner) begin bad++; $display("FAIL %s winner got=%b want=%b", e.tag, winner, e.winner); end
   endtask

   task automatic idle();
      @(negedge clk);
      new_game = 1'b0; result_valid = 1'b0; matchresult = 2'b00;
   endtask

   task automatic release_reset();
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      // Still at time zero region: no clock edge has occurred yet.
      #1;
      model_clear();
      total++;
      if ({round, win, lose, draw, streak} !== 20'd0 || winner !== 2'b00 ||
          game_over !== 1'b0 || result_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_async got r=%0d w=%0d l=%0d d=%0d s=%0d win=%b over=%0b rdy=%0b want zeros/rdy=1",
                  round, win, lose, draw, streak, winner, game_over, result_ready);
      end
      $display("txn reset_async r=%0d over=%0b rdy=%0b", round, game_over, result_ready);
      release_reset();
   endtask

   task automatic test_target_win();
      step("ng", 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) step("win3", 1'b0, 1'b1, 2'b10);
      step("lose_in_over", 1'b0, 1'b1, 2'b11);
   endtask

   task automatic test_streak();
      logic [1:0] seq [7] = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 2'b10};
      step("ng", 1'b1, 1'b0, 2'b00);
      foreach (seq[i]) step("streak_seq", 1'b0, 1'b1, seq[i]);
      total++;
      if (round !== 4'(win + lose + draw)) begin
         bad++;
         $display("FAIL streak_sum round got=%0d want=%0d", round, win + lose + draw);
      end
   endtask

   task automatic test_round_limit();
      logic [1:0] run_b [9] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      logic [1:0] run_c [9] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      step("ng", 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 9; i++) step("draw9", 1'b0, 1'b1, 2'b01);
      step("ng", 1'b1, 1'b0, 2'b00);
      foreach (run_b[i]) step("tie_1v1", 1'b0, 1'b1, run_b[i]);
      step("ng", 1'b1, 1'b0, 2'b00);
      foreach (run_c[i]) step("limit_player", 1'b0, 1'b1, run_c[i]);
   endtask

   task automatic test_ignore();
      step("ng", 1'b1, 1'b0, 2'b00);
      step("one_win", 1'b0, 1'b1, 2'b10);
      for (int i = 0; i < 5; i++) step("valid_low", 1'b0, 1'b0, 2'b10);
      for (int i = 0; i < 5; i++) step("mr_none", 1'b0, 1'b1, 2'b00);
   endtask

   task automatic test_new_game_priority();
      step("ng", 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) step("to_over", 1'b0, 1'b1, 2'b10);
      step("ng_with_win", 1'b1, 1'b1, 2'b10);
      step("mid_w", 1'b0, 1'b1, 2'b10);
      step("mid_l", 1'b0, 1'b1, 2'b11);
      idle();
      resetn = 1'b0;
      #1;
      model_clear();
      total++;
      if ({round, win, lose, draw, streak} !== 20'd0 || winner !== 2'b00 ||
          game_over !== 1'b0 || result_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_midgame got r=%0d w=%0d l=%0d d=%0d s=%0d win=%b over=%0b rdy=%0b want zeros/rdy=1",
                  round, win, lose, draw, streak, winner, game_over, result_ready);
      end
      $display("txn reset_midgame r=%0d w=%0d l=%0d", round, win, lose);
      release_reset();
      step("after_reset", 1'b0, 1'b1, 2'b11);
   endtask

   initial begin
      model_clear();
      test_reset();
      test_target_win();
      test_streak();
      test_round_limit();
      test_ignore();
      test_new_game_priority();
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
